l1_icache_dm: RTL and testbench

- Parametrised direct-mapped, read-only L1 instruction cache. It is the successor to the fixed 64-word instruction store.
- Sits between instruction fetch and the backing program memory.
- Hits return in one cycle. Misses refill a full line from backing memory over a req/ack word handshake; data_ready stays low until the refill completes.
- Adds a whole-cache flush and saturating hit/miss counters.

---
 rtl/l1_icache_dm.sv | 179 +++++++++++++++++
 tb/tb_l1_icache_dm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/l1_icache_dm.sv
// Direct-mapped, read-only L1 instruction cache with word-wise line refill,
// whole-cache flush and saturating hit/miss counters.
module l1_icache_dm #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [DATA_W-1:0] read_data,
    output logic              data_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_AW = INDEX_W + OFFSET_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << LINE_AW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_FILL    = 3'd2;
    localparam logic [2:0] S_RESPOND = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;

    logic [DATA_W-1:0] data_mem [WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid, valid_d;

    logic [2:0]          state, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFFSET_W-1:0] word_cnt, word_cnt_d;
    logic                flush_pend, flush_pend_d;
    logic                req_ready_d, data_ready_d, mem_req_d;
    logic [DATA_W-1:0]   read_data_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [CNT_W-1:0]    hit_count_d, miss_count_d;
    logic                data_we, tag_we;

    logic [TAG_W-1:0]   q_tag;
    logic [INDEX_W-1:0] q_index;
    logic [LINE_AW-1:0] q_word;
    logic               hit;

    assign q_tag   = addr_q[ADDR_W-1:LINE_AW];
    assign q_index = addr_q[LINE_AW-1:OFFSET_W];
    assign q_word  = addr_q[LINE_AW-1:0];
    assign hit     = valid[q_index] && (tag_mem[q_index] == q_tag);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        word_cnt_d   = word_cnt;
        flush_pend_d = flush_pend | flush;
        valid_d      = valid;
        req_ready_d  = req_ready;
        data_ready_d = 1'b0;
        read_data_d  = read_data;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        hit_count_d  = hit_count;
        miss_count_d = miss_count;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state)
            S_IDLE: begin
                // A fresh flush pulse beats a request; a latched one does not
                if (flush) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                    req_ready_d  = 1'b0;
                end else if (req_valid && req_ready) begin
                    addr_d      = req_addr;
                    state_d     = S_LOOKUP;
                    req_ready_d = 1'b0;
                end else if (flush_pend) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                    req_ready_d  = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    read_data_d  = data_mem[q_word];
                    data_ready_d = 1'b1;
                    if (hit_count != '1) hit_count_d = hit_count + CNT_W'(1);
                    state_d      = S_IDLE;
                    req_ready_d  = 1'b1;
                end else begin
                    if (miss_count != '1) miss_count_d = miss_count + CNT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = {q_tag, q_index, OFFSET_W'(0)};
                    word_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_req && mem_ack) begin
                    data_we    = 1'b1;
                    word_cnt_d = word_cnt + OFFSET_W'(1);
                    mem_addr_d = mem_addr + ADDR_W'(1);
                    if (word_cnt == '1) begin
                        tag_we           = 1'b1;
                        valid_d[q_index] = 1'b1;
                        mem_req_d        = 1'b0;
                        state_d          = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                // Final word was written at the previous edge, so the array already holds it
                read_data_d  = data_mem[q_word];
                data_ready_d = 1'b1;
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
            end
            S_FLUSH: begin
                valid_d     = '0;
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            word_cnt   <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
            req_ready  <= 1'b1;
            data_ready <= 1'b0;
            read_data  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clk_en) begin
            state      <= state_d;
            addr_q     <= addr_d;
            word_cnt   <= word_cnt_d;
            flush_pend <= flush_pend_d;
            valid      <= valid_d;
            req_ready  <= req_ready_d;
            data_ready <= data_ready_d;
            read_data  <= read_data_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            hit_count  <= hit_count_d;
            miss_count <= miss_count_d;
        end
    end

    // Data and tag arrays carry no reset
    always_ff @(posedge clk) begin
        if (clk_en && data_we) data_mem[{q_index, word_cnt}] <= mem_rdata;
        if (clk_en && tag_we)  tag_mem[q_index] <= q_tag;
    end
endmodule

// File: tb/tb_l1_icache_dm.sv
// Directed scoreboard bench for l1_icache_dm; a second instance with 2-bit
// counters runs in lockstep to exercise counter saturation.
module tb_l1_icache_dm;
    logic        clk = 1'b0;
    logic        rst, clk_en, req_valid, flush, mem_ack;
    logic [15:0] req_addr;
    logic [31:0] mem_rdata;

    logic        req_ready, data_ready, mem_req;
    logic [31:0] read_data;
    logic [15:0] mem_addr, hit_count, miss_count;

    logic        req_ready_s, data_ready_s, mem_req_s;
    logic [31:0] read_data_s;
    logic [15:0] mem_addr_s;
    logic [1:0]  hit_count_s, miss_count_s;

    int passed = 0;
    int total  = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    l1_icache_dm dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .read_data(read_data), .data_ready(data_ready), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    l1_icache_dm #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_s), .read_data(read_data_s), .data_ready(data_ready_s), .flush(flush),
        .mem_req(mem_req_s), .mem_addr(mem_addr_s), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat3(input int v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    task automatic check_counters();
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_misses));
        check("hit_count_sat", 32'(hit_count_s), sat3(exp_hits));
        check("miss_count_sat", 32'(miss_count_s), sat3(exp_misses));
    endtask

    // One fetch: memory model answers each word after wait_cyc idle cycles
    task automatic request(input logic [15:0] addr, input int wait_cyc, input bit exp_miss,
                           input int flush_at);
        int n, acks, wcnt, budget;
        bit rr_bad, addr_bad;
        logic [15:0] line;
        logic [31:0] exp;
        budget = 0;
        while (!req_ready && budget < 20) begin
            step();
            budget++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        sb.push_back(32'(addr) + 32'h1000);
        if (exp_miss) exp_misses++;
        else exp_hits++;
        line = {addr[15:2], 2'b00};
        acks = 0; wcnt = 0; n = 0; rr_bad = 1'b0; addr_bad = 1'b0;
        while (n < 200) begin
            n++;
            flush = (n == flush_at);
            if (mem_req) begin
                if (mem_addr !== line + 16'(acks)) addr_bad = 1'b1;
                if (wcnt == wait_cyc) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'(mem_addr) + 32'h1000;
                    wcnt      = 0;
                    acks++;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            step();
            flush   = 1'b0;
            mem_ack = 1'b0;
            if (data_ready) break;
            if (req_ready) rr_bad = 1'b1;
        end
        check("data_ready", 32'(data_ready), 32'd1);
        exp = sb.pop_front();
        check("read_data", read_data, exp);
        check("latency", 32'(n), exp_miss ? 32'(6 + 4 * wait_cyc) : 32'd1);
        check("ack_count", 32'(acks), exp_miss ? 32'd4 : 32'd0);
        check("mem_addr_seq", 32'(addr_bad), 32'd0);
        check("req_ready_low", 32'(rr_bad), 32'd0);
        check("sat_read_data", read_data_s, exp);
        step();
        check("pulse_one", 32'(data_ready), 32'd0);
        check_counters();
    endtask

    initial begin
        bit dr_seen;
        rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_addr = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_counters();
        rst = 1'b0;
        step();

        // Cold miss, then hits on the same line
        request(16'h0013, 0, 1'b1, 0);
        request(16'h0013, 0, 1'b0, 0);
        request(16'h0011, 0, 1'b0, 0);

        // Conflict on index 4
        request(16'h0113, 0, 1'b1, 0);
        request(16'h0013, 0, 1'b1, 0);

        // Slow memory
        request(16'h0020, 3, 1'b1, 0);
        request(16'h0022, 0, 1'b0, 0);

        // Flush arriving mid-fill is latched and serviced after the response
        request(16'h0030, 1, 1'b1, 4);
        check("flush_running", 32'(req_ready), 32'd0);
        request(16'h0030, 0, 1'b1, 0);

        // Frozen clock enable: a hit request must not progress
        clk_en = 1'b0; req_valid = 1'b1; req_addr = 16'h0031;
        dr_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (data_ready || !req_ready) dr_seen = 1'b1;
        end
        check("clk_en_freeze", 32'(dr_seen), 32'd0);
        check("clk_en_hold_cnt", 32'(hit_count), 32'(exp_hits));
        req_valid = 1'b0; clk_en = 1'b1;
        request(16'h0031, 0, 1'b0, 0);

        // Reset in the middle of a refill after two acks
        req_valid = 1'b1; req_addr = 16'h0040;
        step();
        req_valid = 1'b0;
        step();
        check("fill_started", 32'(mem_req), 32'd1);
        for (int i = 0; i < 2; i++) begin
            mem_ack = 1'b1;
            mem_rdata = 32'(mem_addr) + 32'h1000;
            step();
        end
        mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        exp_hits = 0; exp_misses = 0;
        check("rstfill_mem_req", 32'(mem_req), 32'd0);
        check("rstfill_req_ready", 32'(req_ready), 32'd1);
        check("rstfill_data_ready", 32'(data_ready), 32'd0);
        check("rstfill_read_data", read_data, 32'd0);
        check("rstfill_mem_addr", 32'(mem_addr), 32'd0);
        check_counters();
        step();
        rst = 1'b0;
        step();
        request(16'h0040, 0, 1'b1, 0);
        for (int i = 0; i < 4; i++) request(16'h0040 + 16'(i), 0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
